joy_poller: RTL and testbench
=============================

// Module: joy_poller
// PURPOSE
//  Autonomous serial-controller poller, replacing the single inline joypad synchroniser.
//  Drives a shared strobe and clock line to NUM_PADS NES/SNES-style shift-register pads.
//  Synchronises each pad's data line and shifts in NUM_BITS bits per pad.
//  Presents a stable, active-high parallel button vector to the NES core and pulses valid per poll.
// PARAMETERS
//  NUM_PADS     2       number of pads sharing strobe/clock, 1..4
//  NUM_BITS     8       bits per pad (8 = NES, 16 = SNES), 2..16
//  CLK_DIV      4       joy_clock half-period in clock cycles, >=4 (covers synchroniser latency)
//  POLL_PERIOD  100000  clock cycles between auto-polls; 0 = auto-poll disabled
// PORTS
//  clock      in   1                  system clock
//  reset      in   1                  asynchronous, active-high
//  start      in   1                  single-cycle manual poll request
//  joy_data   in   NUM_PADS           serial data per pad, active-low (0 = pressed), asynchronous
//  joy_strobe out  1                  latch strobe to pads
//  joy_clock  out  1                  shift clock to pads
//  buttons    out  NUM_PADS*NUM_BITS  bit [p*NUM_BITS+i] = pad p, bit i, 1 = pressed
//  valid      out  1                  one-cycle pulse when buttons updated
//  busy       out  1                  high from trigger until the valid cycle inclusive
// BEHAVIOUR
//  - Reset: joy_strobe=0, joy_clock=0, buttons=0, valid=0, busy=0; FSM=IDLE; poll counter=0; sync flops=1.
//  - joy_data passes a 2-flop synchroniser per pad. Sampling uses the synchronised value, inverted.
//  - Poll counter counts clock cycles in every state.
//    - At POLL_PERIOD-1 it wraps to 0 and raises a trigger.
//    - A trigger or start seen in IDLE starts a poll.
//    - A trigger or start arriving while busy is dropped, not queued.
//  - FSM states: IDLE -> STROBE -> CLK_HI -> CLK_LO -> (CLK_HI ...) -> DONE -> IDLE.
//    - STROBE: joy_strobe=1 for 2*CLK_DIV cycles. Bit 0 is sampled on the last cycle.
//    - CLK_HI: joy_clock=1 for CLK_DIV cycles.
//    - CLK_LO: joy_clock=0 for CLK_DIV cycles. Bit k is sampled on the last cycle.
//    - After bit NUM_BITS-1 is sampled, go to DONE. Otherwise return to CLK_HI.
//    - DONE (1 cycle): buttons updated from the shift registers, valid=1, then IDLE.
//  - Timing:
//    - joy_strobe and joy_clock are registered and never high together.
//    - Poll length is 2*CLK_DIV*NUM_BITS cycles plus 1 DONE cycle.
//    - valid asserts 2*CLK_DIV*NUM_BITS+1 cycles after the start cycle.
//  - Bit counter is $clog2(NUM_BITS) wide and must not wrap before NUM_BITS-1.
//  - Per-pad shift registers are NUM_BITS wide, filled LSB-first (bit 0 = first bit shifted out).
//  - buttons holds its value between polls. It changes only in the DONE cycle.
//  - Disconnected pad (data pulled high) reads as all zeros; no error is flagged.
//  - reset mid-poll: strobe and clock drop asynchronously, partial data is discarded, buttons=0.
// CONFIGURATION
//  JOY_DEBOUNCE_EN defined:
//    - Keeps the previous raw poll result.
//    - In DONE, each button bit takes the new value only if the new and previous raw bits agree.
//    - Otherwise the bit holds. valid still pulses every poll.
//    - The first poll after reset can only confirm against an all-zero previous result.
//  JOY_DEBOUNCE_EN undefined: buttons = raw result of the latest poll. No extra storage.
// TESTING
//  (NUM_PADS=2, NUM_BITS=8, CLK_DIV=4, POLL_PERIOD=0 unless stated; pad models are 4021-style)
//  1 Reset release, no start for 1000 cycles -> strobe=clock=0, busy=0, valid never, buttons=16'h0000
//  2 Pad0 latches 8'hA5 pressed, pad1 8'h3C, start pulse:
//    - strobe high 8 cycles, 7 clock pulses (4 high / 4 low)
//    - valid at cycle 65 after start; buttons=16'h3CA5
//  3 start re-pulsed at cycles 10 and 40 of a poll -> both ignored; exactly one valid; next start polls normally
//  4 POLL_PERIOD=200, pads static at 8'h01/8'h80 -> valid every 200 cycles; buttons=16'h8001 each time
//  5 reset asserted in CLK_LO of bit 4:
//    - strobe and clock go to 0 the same cycle; buttons=0, busy=0
//    - after release, start gives a full correct poll
//  6 JOY_DEBOUNCE_EN, pad0 bit0 toggles pressed/released each poll, other bits steady pressed 8'hFE:
//    - buttons[7:0] settles to 8'hFE after the second poll
//    - bit0 never changes while toggling

Source files
------------

// File: rtl/joy_poller.sv
// Serial NES/SNES pad poller: drives a shared strobe/clock, synchronises each pad's data line
// and publishes an active-high button vector with a valid pulse. Optional: JOY_DEBOUNCE_EN.
module joy_poller #(
    parameter int NUM_PADS    = 2,
    parameter int NUM_BITS    = 8,
    parameter int CLK_DIV     = 4,
    parameter int POLL_PERIOD = 100000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_PADS-1:0]          joy_data,
    output logic                         joy_strobe,
    output logic                         joy_clock,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic                         valid,
    output logic                         busy
);
    localparam int TW = NUM_PADS * NUM_BITS;
    localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);
    localparam logic [CW-1:0] STB_END  = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] PH_END   = CW'(CLK_DIV - 1);
    localparam logic [PW-1:0] POLL_END = PW'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, STROBE, CLK_HI, CLK_LO, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ph_q, ph_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [PW-1:0]   poll_q, poll_d;
    logic [NUM_PADS-1:0] sync1_q, sync2_q;
    logic [TW-1:0]   sr_q, sr_d;
    logic [TW-1:0]   buttons_q, buttons_d, btn_new;
    logic            strobe_q, clk_q, valid_q, busy_q;
    logic            trig, sample;

`ifdef JOY_DEBOUNCE_EN
    // A bit only moves when two consecutive raw polls agree on it.
    logic [TW-1:0] prev_q, agree;
    assign agree   = ~(sr_q ^ prev_q);
    assign btn_new = (buttons_q & ~agree) | (sr_q & agree);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
        end else if (state_q == DONE) begin
            prev_q <= sr_q;
        end
    end
`else
    assign btn_new = sr_q;
`endif

    always_comb begin
        poll_d = '0;
        trig   = 1'b0;
        if (POLL_PERIOD != 0) begin
            if (poll_q == POLL_END) trig = 1'b1;
            else                    poll_d = poll_q + PW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        sr_d      = sr_q;
        sample    = 1'b0;
        buttons_d = buttons_q;
        case (state_q)
            IDLE: begin
                // The valid cycle still counts as busy, so requests there are dropped too.
                if ((start || trig) && !valid_q) begin
                    state_d = STROBE;
                    ph_d    = '0;
                end
            end
            STROBE: begin
                if (ph_q == STB_END) begin
                    sample  = 1'b1;
                    ph_d    = '0;
                    bit_d   = BW'(1);
                    state_d = CLK_HI;
                end else begin
                    ph_d = ph_q + CW'(1);
                end
            end
            CLK_HI: begin
                if (ph_q == PH_END) begin
                    ph_d    = '0;
                    state_d = CLK_LO;
                end else begin
                    ph_d = ph_q + CW'(1);
                end
            end
            CLK_LO: begin
                if (ph_q == PH_END) begin
                    sample = 1'b1;
                    ph_d   = '0;
                    if (bit_q == LAST_BIT) begin
                        state_d = DONE;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        state_d = CLK_HI;
                    end
                end else begin
                    ph_d = ph_q + CW'(1);
                end
            end
            DONE: begin
                buttons_d = btn_new;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Pads shift LSB first, so new bits enter at the top and walk down.
        if (sample) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                sr_d[p*NUM_BITS +: NUM_BITS] = {~sync2_q[p], sr_q[p*NUM_BITS+1 +: NUM_BITS-1]};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ph_q      <= '0;
            bit_q     <= '0;
            poll_q    <= '0;
            sync1_q   <= '1;
            sync2_q   <= '1;
            strobe_q  <= 1'b0;
            clk_q     <= 1'b0;
            buttons_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            bit_q     <= bit_d;
            poll_q    <= poll_d;
            sync1_q   <= joy_data;
            sync2_q   <= sync1_q;
            strobe_q  <= (state_d == STROBE);
            clk_q     <= (state_d == CLK_HI);
            buttons_q <= buttons_d;
            valid_q   <= (state_q == DONE);
            busy_q    <= (state_d != IDLE) || (state_q == DONE);
        end
    end

    always_ff @(posedge clock) begin
        sr_q <= sr_d;
    end

    assign joy_strobe = strobe_q;
    assign joy_clock  = clk_q;
    assign buttons    = buttons_q;
    assign valid      = valid_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_joy_poller.sv
// Directed bench for joy_poller: 4021-style pad models, manual and auto-poll instances.
module tb_joy_poller;
`ifdef JOY_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, rst2, start;
    logic        start2 = 1'b0;
    logic [1:0]  jd1, jd2;
    logic        stb1, jc1, v1, b1, stb2, jc2, v2, b2;
    logic [15:0] btn1, btn2;
    logic [7:0]  p0_btn, p1_btn;
    logic        disc;
    logic [7:0]  pa_sr = 8'hFF, pb_sr = 8'hFF, pc_sr = 8'hFF, pd_sr = 8'hFF;
    int          stb_cyc = 0, clkhi_cyc = 0, clk_pulses = 0, overlap = 0;
    int          vcnt1 = 0, gcyc = 0;
    int          n_chk = 0, n_fail = 0;
    logic [15:0] m_btn, m_prev;

    always #5 clk = ~clk;

    joy_poller #(.NUM_PADS(2), .NUM_BITS(8), .CLK_DIV(4), .POLL_PERIOD(0)) dut (
        .clock(clk), .reset(rst), .start(start), .joy_data(jd1),
        .joy_strobe(stb1), .joy_clock(jc1), .buttons(btn1), .valid(v1), .busy(b1));

    joy_poller #(.NUM_PADS(2), .NUM_BITS(8), .CLK_DIV(4), .POLL_PERIOD(200)) dut_auto (
        .clock(clk), .reset(rst2), .start(start2), .joy_data(jd2),
        .joy_strobe(stb2), .joy_clock(jc2), .buttons(btn2), .valid(v2), .busy(b2));

    // 4021 pads: parallel load while strobe is high, shift toward Q on rising clock, 1s fill in.
    always @(posedge stb1 or posedge jc1) begin
        if (stb1) begin pa_sr <= ~p0_btn; pb_sr <= ~p1_btn; end
        else      begin pa_sr <= {1'b1, pa_sr[7:1]}; pb_sr <= {1'b1, pb_sr[7:1]}; end
    end
    always @(posedge stb2 or posedge jc2) begin
        if (stb2) begin pc_sr <= ~8'h01; pd_sr <= ~8'h80; end
        else      begin pc_sr <= {1'b1, pc_sr[7:1]}; pd_sr <= {1'b1, pd_sr[7:1]}; end
    end
    assign jd1 = {(disc ? 1'b1 : pb_sr[0]), pa_sr[0]};
    assign jd2 = {pd_sr[0], pc_sr[0]};

    always @(negedge clk) begin
        gcyc <= gcyc + 1;
        if (stb1) stb_cyc <= stb_cyc + 1;
        if (jc1) clkhi_cyc <= clkhi_cyc + 1;
        if ((stb1 && jc1) || (stb2 && jc2)) overlap <= overlap + 1;
        if (v1) vcnt1 <= vcnt1 + 1;
    end
    always @(posedge jc1) clk_pulses <= clk_pulses + 1;

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_update(input logic [15:0] raw);
        logic [15:0] agree;
        agree = ~(raw ^ m_prev);
        if (DEB) m_btn = (m_btn & ~agree) | (raw & agree);
        else     m_btn = raw;
        m_prev = raw;
    endtask

    task automatic model_reset;
        m_btn  = '0;
        m_prev = '0;
    endtask

    task automatic do_poll(input logic [7:0] a, input logic [7:0] b, input bit dc,
                           input logic [15:0] raw, input bit repulse);
        int s0, c0, h0, o0, v0, cyc;
        p0_btn = a; p1_btn = b; disc = dc;
        s0 = stb_cyc; c0 = clk_pulses; h0 = clkhi_cyc; o0 = overlap; v0 = vcnt1;
        model_update(raw);
        start = 1'b1;
        step;
        start = 1'b0;
        check("busy_after_start", b1, 1);
        cyc = 0;
        while (!v1 && cyc < 200) begin
            step;
            cyc++;
            start = repulse && (cyc == 10 || cyc == 40);
        end
        start = 1'b0;
        check("valid_latency", cyc, 65);
        check("buttons", btn1, m_btn);
        check("busy_in_valid_cycle", b1, 1);
        step;
        check("valid_one_cycle", v1, 0);
        check("busy_cleared", b1, 0);
        check("strobe_cycles", stb_cyc - s0, 8);
        check("clock_pulses", clk_pulses - c0, 7);
        check("clock_high_cycles", clkhi_cyc - h0, 28);
        check("strobe_clock_overlap", overlap - o0, 0);
        check("valid_count", vcnt1 - v0, 1);
    endtask

    // Start a poll, interrupt it with reset after `at` cycles, check outputs drop immediately.
    task automatic abort_at(input int at, input logic exp_stb, input logic exp_clk);
        int cyc;
        p0_btn = 8'h77; p1_btn = 8'h11;
        start = 1'b1;
        step;
        start = 1'b0;
        for (cyc = 0; cyc < at; cyc++) step;
        check("pre_abort_strobe", stb1, exp_stb);
        check("pre_abort_clock", jc1, exp_clk);
        #1 rst = 1'b1;
        #1;
        check("abort_strobe", stb1, 0);
        check("abort_clock", jc1, 0);
        check("abort_buttons", btn1, 0);
        check("abort_busy", b1, 0);
        model_reset();
        step;
        rst = 1'b0;
        step;
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          dc;
        logic [15:0] raw;
    } vec_t;

    vec_t        vecs[7];
    logic [7:0]  t6_p0[5];
    logic [7:0]  t6_exp[5];

    initial begin
        int v0, cyc, last;
        vecs[0] = '{8'hA5, 8'h3C, 1'b0, 16'h3CA5};
        vecs[1] = '{8'h00, 8'h00, 1'b0, 16'h0000};
        vecs[2] = '{8'hFF, 8'hFF, 1'b0, 16'hFFFF};
        vecs[3] = '{8'h01, 8'h80, 1'b0, 16'h8001};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 16'h0180};
        vecs[5] = '{8'h5A, 8'hC3, 1'b0, 16'hC35A};
        vecs[6] = '{8'h81, 8'hFF, 1'b1, 16'h0081};
        t6_p0 = '{8'hFF, 8'hFE, 8'hFF, 8'hFE, 8'hFF};
        if (DEB) t6_exp = '{8'h00, 8'hFE, 8'hFE, 8'hFE, 8'hFE};
        else     t6_exp = '{8'hFF, 8'hFE, 8'hFF, 8'hFE, 8'hFF};

        rst = 1'b1; rst2 = 1'b1; start = 1'b0; p0_btn = '0; p1_btn = '0; disc = 1'b0;
        model_reset();
        repeat (3) step;
        check("reset_strobe", stb1, 0);
        check("reset_clock", jc1, 0);
        check("reset_buttons", btn1, 0);
        check("reset_valid", v1, 0);
        check("reset_busy", b1, 0);
        rst = 1'b0;

        // Idle after reset: nothing moves without a request.
        repeat (1000) step;
        check("idle_strobe", stb1, 0);
        check("idle_clock", jc1, 0);
        check("idle_busy", b1, 0);
        check("idle_valid_count", vcnt1, 0);
        check("idle_buttons", btn1, 0);

        for (int i = 0; i < 7; i++) do_poll(vecs[i].a, vecs[i].b, vecs[i].dc, vecs[i].raw, 1'b0);
        disc = 1'b0;
        repeat (50) step;
        check("buttons_hold", btn1, m_btn);

        // Requests during a poll are dropped, not queued.
        do_poll(8'hA5, 8'h3C, 1'b0, 16'h3CA5, 1'b1);
        v0 = vcnt1;
        repeat (100) step;
        check("no_queued_poll", vcnt1 - v0, 0);
        do_poll(8'h3C, 8'hA5, 1'b0, 16'hA53C, 1'b0);

        // Reset in STROBE, in CLK_HI of bit 4, and in CLK_LO of bit 4.
        abort_at(3, 1'b1, 1'b0);
        do_poll(8'hA5, 8'h3C, 1'b0, 16'h3CA5, 1'b0);
        abort_at(34, 1'b0, 1'b1);
        abort_at(37, 1'b0, 1'b0);
        do_poll(8'h5A, 8'hC3, 1'b0, 16'hC35A, 1'b0);

        // Bit 0 of pad 0 toggles every poll, the other bits stay pressed.
        rst = 1'b1; model_reset(); step; rst = 1'b0; step;
        for (int i = 0; i < 5; i++) begin
            do_poll(t6_p0[i], 8'h00, 1'b0, {8'h00, t6_p0[i]}, 1'b0);
            check("toggle_pad0", btn1[7:0], t6_exp[i]);
        end

        // Auto-poll every 200 cycles with static pads.
        rst2 = 1'b0;
        cyc = 0;
        last = 0;
        for (int i = 0; i < 4; i++) begin
            cyc = 0;
            while (!v2 && cyc < 400) begin step; cyc++; end
            check("autopoll_seen", v2, 1);
            if (i == 0) check("autopoll_first_latency", cyc, 265);
            else        check("autopoll_period", gcyc - last, 200);
            check("autopoll_buttons", btn2, (i == 0 && DEB) ? 16'h0000 : 16'h8001);
            last = gcyc;
            step;
        end
        check("overlap_total", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks done %0d", n_chk);
        $fatal(1, "watchdog");
    end
endmodule
